// File: rtl/riscv_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle RV32I controller (opcodes, FSM states, mux selects).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Main FSM states; 14 and 15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRA    = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp from the main FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Purpose: maps ALUOp plus funct3/funct7[5]/op[5] onto the ALU operation select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Direct add/sub requests pass through; funct decode otherwise.
  // op5 separates R-type (sub allowed) from I-type (addi only, funct7 is immediate bits).
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b100:  alu_control = ALU_XOR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: Moore main FSM + ALU decoder sequencing the shared multicycle RV32I datapath.
// Latency: LW 5, SW 4, R/I 4, BR 3, JAL 4, JALR 5, LUI 3 cycles including FETCH.
// Backpressure: none; one state per clock, memory assumed single-cycle.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  input  logic               neg,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [2:0]         imm_src,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  state_t     dec_state;
  logic [1:0] alu_op;
  logic       branch_taken;

  assign state = STATE_W'(state_q);

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: opcode dispatch in DECODE and MEMADR, fixed successors elsewhere
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALRA;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_FETCH;   // unknown op retires as a NOP
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;        // ALUWB then writes OldPC+4 into rd
      S_JALRA:    state_d = S_JALRPC;
      S_JALRPC:   state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Branch condition from the SUB flags; overflow is deliberately not folded in
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = neg;
      3'b101:  branch_taken = ~neg;
      default: branch_taken = 1'b0;
    endcase
  end

  // Moore outputs; during reset decode as FETCH with every write enable held low
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    dec_state  = rst ? S_FETCH : state_q;
    case (dec_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        pc_write  = branch_taken;
      end
      S_JAL, S_JALRPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALRA: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      default: begin
      end
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  // Immediate format depends only on the opcode
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BR:   imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      OP_LUI:  imm_src = IMM_U;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: scoreboard bench for multicycle_controller; per-cycle expected outputs queued per instruction.
// Latency: checks instruction latencies from FETCH back to FETCH.
// Backpressure: n/a.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [2:0] imm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       neg;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state;
  exp_t       obs;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .neg         (neg),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .state       (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written straight from the state table
  function automatic logic [2:0] m_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] m_alu_funct(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:  return (o[5] && f75) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] s, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f75, input logic z, input logic n);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.imm = m_imm(o);
    case (s)
      4'd0:  begin e.irw = 1; e.b = 2; e.rs = 2; e.pcw = 1; end
      4'd1:  begin e.a = 1; e.b = 1; end
      4'd2:  begin e.a = 2; e.b = 1; end
      4'd3:  begin e.adr = 1; end
      4'd4:  begin e.rs = 1; e.regw = 1; end
      4'd5:  begin e.adr = 1; e.memw = 1; end
      4'd6:  begin e.a = 2; e.alu = m_alu_funct(o, f3, f75); end
      4'd7:  begin e.a = 2; e.b = 1; e.alu = m_alu_funct(o, f3, f75); end
      4'd8:  begin e.regw = 1; end
      4'd9:  begin e.a = 2; e.alu = 3'd1; e.pcw = m_taken(f3, z, n); end
      4'd10: begin e.a = 1; e.b = 2; e.pcw = 1; end
      4'd11: begin e.a = 2; e.b = 1; end
      4'd12: begin e.a = 1; e.b = 2; e.pcw = 1; end
      4'd13: begin e.rs = 3; e.regw = 1; end
      default: begin end
    endcase
    return e;
  endfunction

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic [6:0] o);
    case (s)
      4'd0: return 4'd1;
      4'd1: begin
        case (o)
          7'b0000011, 7'b0100011: return 4'd2;
          7'b0110011: return 4'd6;
          7'b0010011: return 4'd7;
          7'b1100011: return 4'd9;
          7'b1101111: return 4'd10;
          7'b1100111: return 4'd11;
          7'b0110111: return 4'd13;
          default:    return 4'd0;
        endcase
      end
      4'd2:  return (o == 7'b0100011) ? 4'd5 : 4'd3;
      4'd3:  return 4'd4;
      4'd6, 4'd7, 4'd10, 4'd12: return 4'd8;
      4'd11: return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  // Expected outputs while rst is high: FETCH decode, all write enables low
  function automatic exp_t rst_exp(input logic [3:0] s, input logic [6:0] o);
    exp_t e;
    e      = model(4'd0, o, 3'd0, 1'b0, 1'b0, 1'b0);
    e.st   = s;
    e.pcw  = 0;
    e.irw  = 0;
    return e;
  endfunction

  // Drive one instruction from FETCH, queue the model's per-cycle expectations, drain against the DUT
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f75, input logic z, input logic n, input int lat);
    exp_t       q[$];
    exp_t       e;
    logic [3:0] s;
    int         cycles;
    op = o; funct3 = f3; funct7_5 = f75; zero = z; neg = n;
    s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      q.push_back(model(s, o, f3, f75, z, n));
      s = m_next(s, o);
      if (s == 4'd0) break;
    end
    #1;
    cycles = 0;
    while (cycles < 16) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("%s_c%0d", name, cycles), 32'(obs), 32'(e));
      end else begin
        chk($sformatf("%s_overrun_c%0d", name, cycles), 32'(state), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (state == 4'd0) break;
    end
    chk({name, "_lat"}, 32'(cycles), 32'(lat));
    chk({name, "_left"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; neg = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_hold", 32'(obs), 32'(rst_exp(4'd0, op)));
    rst = 1'b0;

    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4);
    run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 4);
    run_instr("i_add",    7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 4);
    run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4);
    run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 4);
    run_instr("i_xor",    7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 4);
    run_instr("r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 4);
    run_instr("r_sll",    7'b0110011, 3'b001, 1'b1, 1'b0, 1'b0, 4);
    run_instr("beq_t",    7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 3);
    run_instr("bne_nt",   7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 3);
    run_instr("bne_t",    7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3);
    run_instr("blt_t",    7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 3);
    run_instr("bge_nt",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 3);
    run_instr("bge_t",    7'b1100011, 3'b101, 1'b0, 1'b1, 1'b0, 3);
    run_instr("b010_nt",  7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 3);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4);
    run_instr("jalr",     7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 5);
    run_instr("lui",      7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3);
    run_instr("unknown",  7'b1111111, 3'b000, 1'b1, 1'b1, 1'b1, 2);

    // Reset asserted while sitting in MEMWRITE aborts the store
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 10; i++) begin
      if (state == 4'd5) break;
      @(posedge clk); @(negedge clk);
    end
    chk("sw_reach_memwrite", 32'(state), 32'd5);
    rst = 1'b1;
    #1;
    chk("rst_in_memwrite", 32'(obs), 32'(rst_exp(4'd5, op)));
    chk("rst_memw_low", 32'(mem_write), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_to_fetch", 32'(obs), 32'(rst_exp(4'd0, op)));
    @(posedge clk); @(negedge clk);
    chk("rst_held", 32'(obs), 32'(rst_exp(4'd0, op)));
    rst = 1'b0;

    run_instr("lw_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
